// File: rtl/key_latch_pkg.sv
// Shared constants for the key latch: key count, debounce defaults and counter widths.
package key_latch_pkg;
   localparam int NUM_KEYS     = 8;
   localparam int TICK_DIV_DEF = 50000;
   localparam int DB_LEN_DEF   = 4;
   localparam int CNT_W        = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef logic [NUM_KEYS-1:0] keyvec_t;

   function automatic int tick_w(input int div);
      return $clog2(div);
   endfunction

   // agreement counter only has to reach DB_LEN-1
   function automatic int agree_w(input int len);
      return $clog2(len);
   endfunction
endpackage

// File: rtl/key_latch_if.sv
// Key/enable inputs and latched-key outputs of the key latch.
interface key_latch_if;
   import key_latch_pkg::*;

   keyvec_t          keys_n;
   logic             sw_en;
   logic             clr;
   keyvec_t          x;
   logic             en;
   logic             press;
   logic [CNT_W-1:0] press_cnt;

   modport master (output keys_n, sw_en, clr, input x, en, press, press_cnt);
   modport slave  (input keys_n, sw_en, clr, output x, en, press, press_cnt);
endinterface

// File: rtl/key_latch_debounce.sv
// One key: 2-flop synchronizer, tick-sampled debounce and press (0->1) edge detect.
module key_debounce
   import key_latch_pkg::*;
#(
   parameter int DB_LEN = DB_LEN_DEF
) (
   input  logic clk,
   input  logic clrn,
   input  logic tick,
   input  logic raw_n,
   output logic level,
   output logic rise
);
   localparam int AW = agree_w(DB_LEN);
   localparam logic [AW-1:0] LAST = AW'(DB_LEN - 1);

   logic          s1, s2, level_q;
   logic          samp;
   logic [AW-1:0] agree;

   assign samp = ~s2;

   always_ff @(posedge clk) begin
      if (!clrn) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         level   <= 1'b0;
         level_q <= 1'b0;
         agree   <= '0;
      end else begin
         s1      <= raw_n;
         s2      <= s1;
         level_q <= level;
         if (tick) begin
            // any sample matching the current level restarts the run
            if (samp == level)
               agree <= '0;
            else if (agree == LAST) begin
               level <= samp;
               agree <= '0;
            end else
               agree <= agree + 1'b1;
         end
      end
   end

   assign rise = level & ~level_q;
endmodule

// File: rtl/key_latch.sv
// Debounced 8-key press latch with one-cycle press pulse and saturating press count.
module key_latch
   import key_latch_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int DB_LEN   = DB_LEN_DEF
) (
   input  logic       clk,
   input  logic       clrn,
   key_latch_if.slave bus
);
   localparam int TW = tick_w(TICK_DIV);

   logic [TW-1:0] tcnt;
   logic          tick;
   logic          en_s1;
   keyvec_t       level, rise, ev;

   assign tick = (tcnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!clrn)     tcnt <= '0;
      else if (tick) tcnt <= '0;
      else           tcnt <= tcnt + 1'b1;
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(.DB_LEN(DB_LEN)) u_key (
         .clk   (clk),
         .clrn  (clrn),
         .tick  (tick),
         .raw_n (bus.keys_n[i]),
         .level (level[i]),
         .rise  (rise[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         en_s1  <= 1'b0;
         bus.en <= 1'b0;
      end else begin
         en_s1  <= bus.sw_en;
         bus.en <= en_s1;
      end
   end

   assign ev = rise & level;

   // clr takes priority over a press event landing in the same clock
   always_ff @(posedge clk) begin
      if (!clrn || bus.clr) begin
         bus.x         <= '0;
         bus.press     <= 1'b0;
         bus.press_cnt <= '0;
      end else begin
         bus.x     <= bus.x | ev;
         bus.press <= |ev;
         if (|ev && bus.press_cnt != CNT_MAX)
            bus.press_cnt <= bus.press_cnt + 1'b1;
      end
   end
endmodule

// File: doc/key_latch.md
KEY_LATCH -- requirements
Module: key_latch

Interface
REQ-001 Parameter TICK_DIV, default 50000, meaning clocks per debounce sample tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter DB_LEN, default 4, meaning consecutive equal samples required to accept a key level change; legal range 2..8.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 clrn  input  1  reset, synchronous, active-low.
REQ-005 keys_n  input  8  raw push-buttons, active-low, asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of latched keys and press count, active-high.
REQ-007 sw_en  input  1  raw enable switch, asynchronous, active-high.
REQ-008 x  output  8  latched key vector, bit i = key i pressed since last clear; feeds the priority encoder x input.
REQ-009 en  output  1  synchronized sw_en; feeds the encoder en input.
REQ-010 press  output  1  one-clock pulse on any accepted press event.
REQ-011 press_cnt  output  4  saturating count of press events since last clear.

Function
REQ-012 keys_n and sw_en SHALL each pass a 2-flop synchronizer before any other use; keys are inverted after synchronization (pressed = 1).
REQ-013 A free-running tick counter SHALL count 0..TICK_DIV-1 and wrap, asserting tick for exactly one clock when the count equals TICK_DIV-1.
REQ-014 Each key SHALL have a debounced level db[i], changed only on a tick, and only after DB_LEN consecutive tick samples all differ from the current db[i].
REQ-015 Any sample equal to db[i] SHALL restart that key's agreement count at zero.
REQ-016 A press event for key i SHALL be the clock in which db[i] goes 0->1; a 1->0 transition (release) SHALL NOT generate an event or modify x.
REQ-017 On a press event, x[i] SHALL be set 1 one clock later; set bits stay set until clr or reset (accumulate, OR semantics).
REQ-018 press SHALL be high in the clock x updates, once per clock regardless of how many keys produced events in that tick.
REQ-019 press_cnt SHALL increment by 1 in each clock press is high, saturating at 15 (no wrap).
REQ-020 clr high SHALL force x = 0 and press_cnt = 0 next clock; a press event in the same clock as clr SHALL be dropped (clr wins, press stays low).
REQ-021 clr SHALL NOT affect the tick counter, synchronizers, or debounce state.
REQ-022 en SHALL equal sw_en delayed by the 2-flop synchronizer; en has no debounce.
REQ-023 Latency from a clean key press to x update SHALL be 2 (sync) + up to TICK_DIV*DB_LEN + 1 clocks.

Reset
REQ-024 When clrn = 0 at a clock edge: x = 0, press = 0, press_cnt = 0, en = 0, tick counter = 0, all db[i] = 0, all agreement counts = 0, synchronizer flops = released/disabled level.
REQ-025 Reset mid-debounce SHALL discard partial agreement; a key still held after reset SHALL produce a press event after a full DB_LEN ticks.

Structure
REQ-026 TICK_DIV and DB_LEN defaults and the counter width calculations SHALL live in the team's shared constants package/header.
REQ-027 Per-key synchronizer plus debounce plus rising-edge detection SHALL be one sub-module, key_debounce (ports clk, clrn, tick, raw_n, level, rise), instantiated 8 times.
REQ-028 key_latch SHALL contain only the tick counter, sw_en synchronizer, x register, press and press_cnt logic.

Verification (TICK_DIV=4, DB_LEN=4 in simulation)
REQ-029 Reset then keys_n=8'hFF, sw_en=1 for 100 clocks -> x=8'h00, press never high, press_cnt=0, en=1 from clock 3.
REQ-030 Hold keys_n[5]=0 for 40 clocks -> single press pulse, x=8'h20, press_cnt=1, pulse at no earlier than clock 2+13 after assertion.
REQ-031 Bounce keys_n[2] toggling every 3 clocks for 30 clocks, then release -> x unchanged, press never high.
REQ-032 Press keys 0 and 7 simultaneously, held 40 clocks -> one press pulse, x=8'h81, press_cnt=1.
REQ-033 Issue 17 separate clean presses of key 1 -> press_cnt saturates at 15; then clr coincident with an 18th press event -> x=8'h00, press_cnt=0, press low.
REQ-034 Hold key 3 and pulse clrn low for 1 clock after 2 ticks -> x=8'h00 after reset; press event follows a full 4 further ticks, x=8'h08.
